// File: rtl/reg_access_pkg.sv
// ---------------------------------------------------------------------------
// reg_access_pkg
// Shared definitions for the register access sequencer: the data width of
// the attached register, the sequencer state encoding and the request
// operation encoding carried on req_write.
// ---------------------------------------------------------------------------
package reg_access_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/reg_access_seq.sv
// ---------------------------------------------------------------------------
// reg_access_seq
// Sequences single host requests (read or write) onto a 16-bit register
// with write_enable / read_enable strobes, and returns exactly one response
// per accepted request through a valid/ready handshake.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_write, req_wdata       operation (1 = write) and write data
//   rsp_valid/rsp_ready        response handshake, held until accepted
//   rsp_rdata, rsp_err         read data / read-back value, mismatch flag
//   reg_write_enable,
//   reg_read_enable,
//   reg_data_in                strobes and data towards the register
//   reg_data_out               register output, valid one edge after a read
//
// Build option
//   REG_ACCESS_VERIFY_EN       when defined, every write is followed by a
//                              read-back; rsp_rdata returns the read-back
//                              value and rsp_err flags a mismatch.
// ---------------------------------------------------------------------------
module reg_access_seq
    import reg_access_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              reg_write_enable,
    output logic              reg_read_enable,
    output logic [DATA_W-1:0] reg_data_in,
    input  logic [DATA_W-1:0] reg_data_out
);

`ifdef REG_ACCESS_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    state_e state;
    op_e    op;

    // Every output is a flop loaded together with the next state, so the
    // strobe for a state is visible for exactly the cycle spent in it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            op               <= OP_READ;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b0;
            reg_write_enable <= 1'b0;
            reg_read_enable  <= 1'b0;
            reg_data_in      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        reg_data_in <= req_wdata;
                        op          <= op_e'(req_write);
                        if (req_write) begin
                            state            <= WR;
                            reg_write_enable <= 1'b1;
                        end else begin
                            state           <= RD;
                            reg_read_enable <= 1'b1;
                        end
                    end
                end
                WR: begin
                    reg_write_enable <= 1'b0;
                    if (VERIFY_EN) begin
                        // Read the value straight back so CAP can compare it
                        // against the data just written.
                        state           <= RD;
                        reg_read_enable <= 1'b1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                RD: begin
                    // The register presents its data one edge after the
                    // read strobe, so CAP waits a cycle before sampling.
                    reg_read_enable <= 1'b0;
                    state           <= CAP;
                end
                CAP: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= reg_data_out;
                    rsp_err   <= VERIFY_EN && (op == OP_WRITE) &&
                                 (reg_data_out != reg_data_in);
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings fall back to a clean idle.
                    state            <= IDLE;
                    req_ready        <= 1'b1;
                    rsp_valid        <= 1'b0;
                    rsp_err          <= 1'b0;
                    reg_write_enable <= 1'b0;
                    reg_read_enable  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_access_seq.md
REG_ACCESS_SEQ -- requirements
Module: reg_access_seq

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req_valid  in  1  host request present.
REQ-004 SHALL have port: req_ready  out  1  sequencer can accept a request.
REQ-005 SHALL have port: req_write  in  1  1 = write, 0 = read.
REQ-006 SHALL have port: req_wdata  in  16  write data.
REQ-007 SHALL have port: rsp_valid  out  1  response present.
REQ-008 SHALL have port: rsp_ready  in  1  host accepts response.
REQ-009 SHALL have port: rsp_rdata  out  16  read data or read-back value.
REQ-010 SHALL have port: rsp_err  out  1  read-back mismatch flag.
REQ-011 SHALL have port: reg_write_enable  out  1  to the 16-bit register's write_enable.
REQ-012 SHALL have port: reg_read_enable  out  1  to the 16-bit register's read_enable.
REQ-013 SHALL have port: reg_data_in  out  16  to the register's data_in.
REQ-014 SHALL have port: reg_data_out  in  16  from the register's data_out; updates one edge after a read enable.

Function
REQ-015 SHALL implement FSM states IDLE, WR, RD, CAP, RESP; all outputs registered.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge with req_valid&req_ready.
REQ-017 SHALL latch req_wdata into reg_data_in and req_write internally on acceptance.
REQ-018 SHALL transition IDLE->WR on an accepted write and IDLE->RD on an accepted read.
REQ-019 SHALL assert reg_write_enable for exactly one cycle in WR and reg_read_enable for exactly one cycle in RD; the two are never both high.
REQ-020 SHALL go RD->CAP and sample reg_data_out into rsp_rdata at the end of CAP, then enter RESP.
REQ-021 SHALL give read latency: rsp_valid high 3 cycles after the acceptance edge.
REQ-022 SHALL (without verify) go WR->RESP with rsp_rdata=0 and rsp_err=0, giving rsp_valid 2 cycles after acceptance.
REQ-023 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-024 SHALL stay in RESP indefinitely while rsp_ready=0, with both register enables low.
REQ-025 SHALL ignore req_valid while not in IDLE; the earliest next acceptance is the cycle after the response handshake.
REQ-026 SHALL produce exactly one response per accepted request, in order.

Reset
REQ-027 SHALL on reset force IDLE, with req_ready=1 on the first cycle after reset and rsp_valid, rsp_err, both enables, rsp_rdata and reg_data_in all 0.
REQ-028 SHALL on reset mid-operation drop the in-flight request with no response; reset overrides all other inputs.

Configuration
REQ-029 SHALL, with macro REG_ACCESS_VERIFY_EN defined, sequence writes IDLE->WR->RD->CAP->RESP (rsp_valid 4 cycles after acceptance), return the read-back value in rsp_rdata, and set rsp_err=1 iff the read-back differs from the latched write data.
REQ-030 SHALL, without REG_ACCESS_VERIFY_EN, behave per REQ-022 and tie rsp_err to 0.

Structure
REQ-031 SHALL take the state enum type, the data width constant (16) and the op encoding (write/read) from package reg_access_pkg.
REQ-032 SHALL be a single FSM module with no sub-module.

Verification
REQ-033 SHALL check: write 16'hA5A5 with rsp_ready=1 -> reg_write_enable high in cycle 1 with reg_data_in=A5A5; rsp_valid in cycle 2 with rdata=0 and err=0.
REQ-034 SHALL check: write 16'h1234 then read -> reg_read_enable high in cycle 1 after acceptance; rsp_valid in cycle 3 with rsp_rdata=1234.
REQ-035 SHALL check: read with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, and a second req_valid is not accepted.
REQ-036 SHALL check: reset asserted during RD -> next cycle IDLE with all outputs 0 except req_ready=1, and no response.
REQ-037 SHALL check (REG_ACCESS_VERIFY_EN): write 16'hBEEF -> rsp_valid in cycle 4 with rdata=BEEF and err=0; with the register model forced to return 16'hBEEE -> err=1.
REQ-038 SHALL check: back-to-back requests with req_valid held high -> reg_write_enable and reg_read_enable are never high together, and responses come one per request.
